// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions the raw board switches and push-buttons for the tail-light
// controller. Each channel is synchronized through two flops. An independent
// STABLE/COUNTING state machine then accepts a new level only after
// DEBOUNCE_CYCLES consecutive synchronized samples that differ from the
// current debounced level. When a new level is accepted, the channel emits a
// one-cycle press or release pulse.
//
// Channel map: [2:0] = SW[2:0], [4:3] = KEY[1:0].
//
// Ports
//   clock          system clock
//   reset          asynchronous, active-high reset
//   raw_in         asynchronous pin levels
//   level_out      debounced level, same polarity as raw_in
//   press_pulse    one-cycle pulse when level_out leaves IDLE_LEVEL
//   release_pulse  one-cycle pulse when level_out returns to IDLE_LEVEL
//   busy           channel is currently counting a candidate level
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int                  CHANNELS        = 5,
   parameter int                  DEBOUNCE_CYCLES = 100000,
   parameter logic [CHANNELS-1:0] IDLE_LEVEL      = 5'b11000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] busy
);

   // The counter only has to hold values up to DEBOUNCE_CYCLES-1.
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } state_e;

   logic [CHANNELS-1:0] sync1_r;
   logic [CHANNELS-1:0] sync2_r;

   // Two-flop synchronizer. It resets to the idle level, so a pin held
   // non-idle through reset is seen as a fresh change after reset release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_r <= IDLE_LEVEL;
         sync2_r <= IDLE_LEVEL;
      end else begin
         sync1_r <= raw_in;
         sync2_r <= sync1_r;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_e        state_r;
      state_e        state_nxt_s;
      logic [CW-1:0] cnt_r;
      logic [CW-1:0] cnt_nxt_s;
      logic          level_r;
      logic          level_nxt_s;
      logic          press_r;
      logic          press_nxt_s;
      logic          release_r;
      logic          release_nxt_s;
      logic          busy_r;

      // Next-state logic for one channel: accept, keep counting, or abort on
      // the first sample that agrees with the current level.
      always_comb begin
         state_nxt_s   = state_r;
         cnt_nxt_s     = cnt_r;
         level_nxt_s   = level_r;
         press_nxt_s   = 1'b0;
         release_nxt_s = 1'b0;
         case (state_r)
            ST_STABLE: begin
               if (sync2_r[i] != level_r) begin
                  state_nxt_s = ST_COUNTING;
                  cnt_nxt_s   = CNT_ONE;
               end else begin
                  cnt_nxt_s   = CNT_ZERO;
               end
            end
            ST_COUNTING: begin
               if (sync2_r[i] == level_r) begin
                  state_nxt_s = ST_STABLE;
                  cnt_nxt_s   = CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  // Pulse direction follows the level being entered, so press
                  // and release can never fire together on one channel.
                  state_nxt_s   = ST_STABLE;
                  cnt_nxt_s     = CNT_ZERO;
                  level_nxt_s   = sync2_r[i];
                  press_nxt_s   = (sync2_r[i] != IDLE_LEVEL[i]);
                  release_nxt_s = (sync2_r[i] == IDLE_LEVEL[i]);
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_nxt_s = ST_STABLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         endcase
      end

      // Per-channel state, counter and output registers.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state_r   <= ST_STABLE;
            cnt_r     <= CNT_ZERO;
            level_r   <= IDLE_LEVEL[i];
            press_r   <= 1'b0;
            release_r <= 1'b0;
            busy_r    <= 1'b0;
         end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            busy_r    <= (state_nxt_s == ST_COUNTING);
         end
      end

      assign level_out[i]     = level_r;
      assign press_pulse[i]   = press_r;
      assign release_pulse[i] = release_r;
      assign busy[i]          = busy_r;
   end

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer. It uses one instance with
// DEBOUNCE_CYCLES=4 for the functional scenarios and one instance with
// DEBOUNCE_CYCLES=8 for the reset-mid-count case. Every expected value is
// hand-derived from the edge schedule: sync1 captures at E1, sync2 at E2,
// COUNTING starts at E3, and the new level appears at E(D+2).
// -----------------------------------------------------------------------------
module tb_input_debouncer;

   logic       clock;
   logic       rst4_s;
   logic       rst8_s;
   logic [4:0] raw4_s;
   logic [4:0] raw8_s;
   logic [4:0] level4_s, press4_s, rel4_s, busy4_s;
   logic [4:0] level8_s, press8_s, rel8_s, busy8_s;

   int total_r;
   int bad_r;

   input_debouncer #(
      .CHANNELS(5), .DEBOUNCE_CYCLES(4), .IDLE_LEVEL(5'b11000)
   ) dut4 (
      .clock(clock), .reset(rst4_s), .raw_in(raw4_s),
      .level_out(level4_s), .press_pulse(press4_s),
      .release_pulse(rel4_s), .busy(busy4_s)
   );

   input_debouncer #(
      .CHANNELS(5), .DEBOUNCE_CYCLES(8), .IDLE_LEVEL(5'b11000)
   ) dut8 (
      .clock(clock), .reset(rst8_s), .raw_in(raw8_s),
      .level_out(level8_s), .press_pulse(press8_s),
      .release_pulse(rel8_s), .busy(busy8_s)
   );

   // Free-running clock, 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total_r, bad_r);
      $fatal(1, "time bound expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_r++;
      if (obs !== exp) begin
         bad_r++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Check edges E1..E7 on dut4 after an input change made just after E0.
   task automatic transit4(input string tag, input logic [4:0] old_lvl,
                           input logic [4:0] new_lvl, input logic [4:0] exp_p,
                           input logic [4:0] exp_r, input logic [4:0] exp_b);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk({tag, "_lvl"},  {27'd0, level4_s}, {27'd0, (k >= 6) ? new_lvl : old_lvl});
         chk({tag, "_prs"},  {27'd0, press4_s}, {27'd0, (k == 6) ? exp_p : 5'b00000});
         chk({tag, "_rel"},  {27'd0, rel4_s},   {27'd0, (k == 6) ? exp_r : 5'b00000});
         chk({tag, "_busy"}, {27'd0, busy4_s},
             {27'd0, (k >= 3 && k <= 5) ? exp_b : 5'b00000});
      end
   endtask

   initial begin
      logic [9:0] pat_s;
      total_r = 0;
      bad_r   = 0;
      rst4_s  = 1'b1;
      rst8_s  = 1'b1;
      raw4_s  = 5'b00111;
      raw8_s  = 5'b11000;

      // Reset values with non-idle pins held.
      tick();
      tick();
      chk("rst_lvl",  {27'd0, level4_s}, {27'd0, 5'b11000});
      chk("rst_prs",  {27'd0, press4_s}, 32'd0);
      chk("rst_rel",  {27'd0, rel4_s},   32'd0);
      chk("rst_busy", {27'd0, busy4_s},  32'd0);

      // Every bit of 00111 differs from the idle level 11000, so all five
      // channels are re-debounced and all five report a press.
      rst4_s = 1'b0;
      transit4("rel_rst", 5'b11000, 5'b00111, 5'b11111, 5'b00000, 5'b11111);

      // Return everything to idle: five release pulses.
      raw4_s = 5'b11000;
      transit4("idle", 5'b00111, 5'b11000, 5'b00000, 5'b11111, 5'b11111);

      // Clean press and release of KEY0 (channel 3).
      raw4_s = 5'b10000;
      transit4("k0_prs", 5'b11000, 5'b10000, 5'b01000, 5'b00000, 5'b01000);
      raw4_s = 5'b11000;
      transit4("k0_rel", 5'b10000, 5'b11000, 5'b00000, 5'b01000, 5'b01000);

      // Bounce on channel 0: 0,1,0,1 then held 0. busy is seen after E4 and E6.
      pat_s = 10'b00_0000_1010;
      for (int j = 0; j < 10; j++) begin
         raw4_s[0] = pat_s[j];
         tick();
         chk("bnc_lvl",  {27'd0, level4_s}, {27'd0, 5'b11000});
         chk("bnc_prs",  {27'd0, press4_s}, 32'd0);
         chk("bnc_rel",  {27'd0, rel4_s},   32'd0);
         chk("bnc_busy", {27'd0, busy4_s},
             {27'd0, (j == 3 || j == 5) ? 5'b00001 : 5'b00000});
      end

      // Channel 1 glitches high for two cycles, drops, then holds high.
      // The count restarts at E6 and the level is accepted at E9.
      pat_s = 10'b11_1111_1011;
      for (int j = 0; j < 10; j++) begin
         raw4_s[1] = pat_s[j];
         tick();
         chk("set_lvl", {27'd0, level4_s},
             {27'd0, (j >= 8) ? 5'b11010 : 5'b11000});
         chk("set_prs", {27'd0, press4_s},
             {27'd0, (j == 8) ? 5'b00010 : 5'b00000});
         chk("set_rel", {27'd0, rel4_s}, 32'd0);
         chk("set_busy", {27'd0, busy4_s},
             {27'd0, (j == 2 || j == 3 || j == 5 || j == 6 || j == 7) ? 5'b00010 : 5'b00000});
      end
      raw4_s = 5'b11000;
      transit4("set_back", 5'b11010, 5'b11000, 5'b00000, 5'b00010, 5'b00010);

      // All channels change in the same cycle.
      raw4_s = 5'b00111;
      transit4("simul", 5'b11000, 5'b00111, 5'b11111, 5'b00000, 5'b11111);

      // D=8 instance: reset in the middle of a count.
      rst8_s = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("d8_idle_lvl",  {27'd0, level8_s}, {27'd0, 5'b11000});
         chk("d8_idle_busy", {27'd0, busy8_s},  32'd0);
      end
      raw8_s = 5'b11100;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("d8_pre_busy", {27'd0, busy8_s},
             {27'd0, (k >= 3) ? 5'b00100 : 5'b00000});
      end
      #2;
      rst8_s = 1'b1;
      #1;
      chk("d8_mid_busy", {27'd0, busy8_s},  32'd0);
      chk("d8_mid_lvl",  {27'd0, level8_s}, {27'd0, 5'b11000});
      chk("d8_mid_prs",  {27'd0, press8_s}, 32'd0);
      tick();
      rst8_s = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         chk("d8_lvl", {27'd0, level8_s},
             {27'd0, (k >= 10) ? 5'b11100 : 5'b11000});
         chk("d8_prs", {27'd0, press8_s},
             {27'd0, (k == 10) ? 5'b00100 : 5'b00000});
         chk("d8_rel", {27'd0, rel8_s}, 32'd0);
         chk("d8_busy", {27'd0, busy8_s},
             {27'd0, (k >= 3 && k <= 9) ? 5'b00100 : 5'b00000});
      end

      $display("test done: total=%0d bad=%0d", total_r, bad_r);
      $finish;
   end

endmodule
